// File: rtl/simd_pkg.sv
// ----------------------------------------------------------------------------
// simd_pkg
// Shared definitions for the 4-lane SIMD array controller:
//   - NLANES        : number of arithmetic lanes driven by the sequencer
//   - ST_*          : sequencer FSM state encodings (IDLE/LOAD/SETTLE/SEND/DONE)
//   - simd_mode_e   : ALU mode encoding, shared with the lane ALUs
//   - seq_cnt_width : width of the phase bit counter
// ----------------------------------------------------------------------------
package simd_pkg;

    localparam int NLANES = 4;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE   = 3'd0;
    localparam seq_state_t ST_LOAD   = 3'd1;
    localparam seq_state_t ST_SETTLE = 3'd2;
    localparam seq_state_t ST_SEND   = 3'd3;
    localparam seq_state_t ST_DONE   = 3'd4;

    typedef enum logic [3:0] {
        MODE_ADD    = 4'h0,
        MODE_SUB    = 4'h1,
        MODE_AND    = 4'h2,
        MODE_OR     = 4'h3,
        MODE_XOR    = 4'h4,
        MODE_PASS_A = 4'h5,
        MODE_PASS_B = 4'h6
    } simd_mode_e;

    // The longest phase (SEND) runs BW+PISO_LAT cycles; the counter must hold
    // that value without wrapping.
    function automatic int seq_cnt_width(input int bw, input int piso_lat);
        return $clog2(bw + piso_lat + 1);
    endfunction

endpackage

// File: rtl/simd_seq_shifter.sv
// ----------------------------------------------------------------------------
// simd_seq_shifter
// One BW-bit shift register, MSB-first in both directions.
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset, clears the register
//   i_load   : parallel load of i_pdata (wins over i_shift)
//   i_pdata  : parallel load data
//   i_shift  : shift left one place, i_sin enters at the LSB
//   i_sin    : serial input
//   o_sout   : serial output (current MSB)
//   o_pdata  : parallel output (current register contents)
// ----------------------------------------------------------------------------
module simd_seq_shifter
    import simd_pkg::*;
#(
    parameter int BW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [BW-1:0] i_pdata,
    input  logic          i_shift,
    input  logic          i_sin,
    output logic          o_sout,
    output logic [BW-1:0] o_pdata
);

    logic [BW-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_pdata;
        end else if (i_shift) begin
            r_data <= {r_data[BW-2:0], i_sin};
        end
    end

    assign o_sout  = r_data[BW-1];
    assign o_pdata = r_data;

endmodule

// File: rtl/simd_lane_sequencer.sv
// ----------------------------------------------------------------------------
// simd_lane_sequencer
// Controller on both sides of the 4-lane SIMD array. Accepts a bundle of four
// operand pairs plus mode/dtype, shifts the operands into the lanes MSB-first
// with o_load high, waits SETTLE cycles, pulses o_send for BW cycles and
// collects the four serial result streams into parallel words.
//
// Ports:
//   i_clk        : clock, all logic on the rising edge
//   i_rst_n      : asynchronous active-low reset (aborts any operation)
//   i_in_valid   : operand bundle valid
//   o_in_ready   : bundle can be accepted (IDLE only)
//   i_in_a/b     : lane operands, lane0 in [BW-1:0]
//   i_in_mode    : ALU mode, latched at accept
//   i_in_dtype   : ALU dtype, latched at accept
//   o_load       : high for the BW cycles of LOAD
//   o_lane_bits  : {B3,A3,B2,A2,B1,A1,B0,A0} current operand bit, MSB first
//   o_mode       : latched mode, held from accept to result handshake
//   o_dtype      : latched dtype, same lifetime as o_mode
//   o_send       : high for the first BW cycles of SEND
//   i_res_bits   : serial results from the lanes, bit i = lane i
//   o_out_valid  : result bundle valid (DONE), held until i_out_ready
//   i_out_ready  : consumer accepts the result bundle
//   o_out_res    : captured results, lane0 in [BW-1:0]
//   o_op_count   : (SIMD_SEQ_OPCNT_EN only) completed result handshakes,
//                  wraps 0xFFFF -> 0
//
// Build option: define SIMD_SEQ_OPCNT_EN to add the o_op_count port/counter.
// SETTLE is assumed to be in 1..BW+PISO_LAT so it fits the phase counter.
// ----------------------------------------------------------------------------
module simd_lane_sequencer
    import simd_pkg::*;
#(
    parameter int BW       = 32,
    parameter int PISO_LAT = 1,
    parameter int SETTLE   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [NLANES*BW-1:0]   i_in_a,
    input  logic [NLANES*BW-1:0]   i_in_b,
    input  logic [3:0]             i_in_mode,
    input  logic                   i_in_dtype,
    output logic                   o_load,
    output logic [2*NLANES-1:0]    o_lane_bits,
    output logic [3:0]             o_mode,
    output logic                   o_dtype,
    output logic                   o_send,
    input  logic [NLANES-1:0]      i_res_bits,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [NLANES*BW-1:0]   o_out_res
`ifdef SIMD_SEQ_OPCNT_EN
    ,
    output logic [15:0]            o_op_count
`endif
);

    localparam int CNT_W = seq_cnt_width(BW, PISO_LAT);

    localparam logic [CNT_W-1:0] C_LOAD_LAST   = CNT_W'(BW - 1);
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] C_SEND_LAST   = CNT_W'(BW + PISO_LAT - 1);
    localparam logic [CNT_W-1:0] C_SEND_BW     = CNT_W'(BW);
    localparam logic [CNT_W-1:0] C_CAP_FIRST   = CNT_W'(PISO_LAT);
    localparam logic [CNT_W-1:0] C_CAP_END     = CNT_W'(PISO_LAT + BW);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_mode;
    logic             r_dtype;

    logic w_accept;
    logic w_out_hs;
    logic w_in_load;
    logic w_in_send;
    logic w_counting;
    logic w_capture;

    assign w_accept   = i_in_valid && (r_state == ST_IDLE);
    assign w_out_hs   = i_out_ready && (r_state == ST_DONE);
    assign w_in_load  = (r_state == ST_LOAD);
    assign w_in_send  = (r_state == ST_SEND);
    // Only the timed phases advance the counter; IDLE and DONE may last
    // indefinitely and must not let it wander.
    assign w_counting = w_in_load || w_in_send || (r_state == ST_SETTLE);
    // Result bits arrive PISO_LAT cycles after send rises and stay for BW cycles.
    assign w_capture  = w_in_send && (r_cnt >= C_CAP_FIRST) && (r_cnt < C_CAP_END);

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)                 w_state_next = ST_LOAD;
            ST_LOAD:   if (r_cnt == C_LOAD_LAST)     w_state_next = ST_SETTLE;
            ST_SETTLE: if (r_cnt == C_SETTLE_LAST)   w_state_next = ST_SEND;
            ST_SEND:   if (r_cnt == C_SEND_LAST)     w_state_next = ST_DONE;
            ST_DONE:   if (i_out_ready)              w_state_next = ST_IDLE;
            default:                                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            // Every phase starts counting from zero.
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Mode/dtype are captured once per operation so the lanes see a stable
    // value even if the producer changes its inputs right after accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode  <= '0;
            r_dtype <= 1'b0;
        end else if (w_accept) begin
            r_mode  <= i_in_mode;
            r_dtype <= i_in_dtype;
        end
    end

`ifdef SIMD_SEQ_OPCNT_EN
    logic [15:0] r_op_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_count <= '0;
        end else if (w_out_hs) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign o_op_count = r_op_count;
`endif

    // ------------------------------------------------------------------
    // Shift registers: operands are parallel-loaded at accept and shifted
    // out during LOAD; results are shifted in during the capture window.
    // ------------------------------------------------------------------
    logic [2*NLANES-1:0] w_op_msb;
    logic [2*NLANES-1:0] w_op_par_x;
    logic [NLANES-1:0]   w_res_sout;
    logic [BW-1:0]       w_op_par [2*NLANES];
    logic                w_unused;

    genvar gi;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : g_lane
            simd_seq_shifter #(.BW(BW)) u_op_a (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_load  (w_accept),
                .i_pdata (i_in_a[gi*BW +: BW]),
                .i_shift (w_in_load),
                .i_sin   (1'b0),
                .o_sout  (w_op_msb[2*gi]),
                .o_pdata (w_op_par[2*gi])
            );

            simd_seq_shifter #(.BW(BW)) u_op_b (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_load  (w_accept),
                .i_pdata (i_in_b[gi*BW +: BW]),
                .i_shift (w_in_load),
                .i_sin   (1'b0),
                .o_sout  (w_op_msb[2*gi+1]),
                .o_pdata (w_op_par[2*gi+1])
            );

            simd_seq_shifter #(.BW(BW)) u_res (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_load  (1'b0),
                .i_pdata ({BW{1'b0}}),
                .i_shift (w_capture),
                .i_sin   (i_res_bits[gi]),
                .o_sout  (w_res_sout[gi]),
                .o_pdata (o_out_res[gi*BW +: BW])
            );

            // The array only sees operand bits while load is high.
            assign o_lane_bits[2*gi]   = w_in_load & w_op_msb[2*gi];
            assign o_lane_bits[2*gi+1] = w_in_load & w_op_msb[2*gi+1];
        end

        for (gi = 0; gi < 2*NLANES; gi++) begin : g_par_fold
            assign w_op_par_x[gi] = ^w_op_par[gi];
        end
    endgenerate

    // Operand parallel outputs and result serial outputs have no consumer here.
    assign w_unused = ^{w_op_par_x, w_res_sout};

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_load      = w_in_load;
    assign o_send      = w_in_send && (r_cnt < C_SEND_BW);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_mode      = r_mode;
    assign o_dtype     = r_dtype;

endmodule

// File: tb/tb_simd_lane_sequencer.sv
`timescale 1ns/1ps
module tb_simd_lane_sequencer;
    import simd_pkg::*;

    localparam int BW       = 32;
    localparam int PISO_LAT = 1;
    localparam int SETTLE   = 1;
    localparam int LAT      = 2*BW + SETTLE + PISO_LAT + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [4*BW-1:0] in_a = '0;
    logic [4*BW-1:0] in_b = '0;
    logic [3:0]      in_mode = '0;
    logic            in_dtype = 1'b0;
    logic            out_ready = 1'b0;
    logic [3:0]      res_bits = '0;

    logic            o_in_ready;
    logic            o_load;
    logic [7:0]      o_lane_bits;
    logic [3:0]      o_mode;
    logic            o_dtype;
    logic            o_send;
    logic            o_out_valid;
    logic [4*BW-1:0] o_out_res;
`ifdef SIMD_SEQ_OPCNT_EN
    logic [15:0]     o_op_count;
`endif

    simd_lane_sequencer #(.BW(BW), .PISO_LAT(PISO_LAT), .SETTLE(SETTLE)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_a      (in_a),
        .i_in_b      (in_b),
        .i_in_mode   (in_mode),
        .i_in_dtype  (in_dtype),
        .o_load      (o_load),
        .o_lane_bits (o_lane_bits),
        .o_mode      (o_mode),
        .o_dtype     (o_dtype),
        .o_send      (o_send),
        .i_res_bits  (res_bits),
        .o_out_valid (o_out_valid),
        .i_out_ready (out_ready),
        .o_out_res   (o_out_res)
`ifdef SIMD_SEQ_OPCNT_EN
        ,
        .o_op_count  (o_op_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    // ------------------------------------------------------------------
    // Reference ALU: what a lane computes for one operand pair.
    // ------------------------------------------------------------------
    function automatic logic [BW-1:0] alu_ref(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                              input logic [3:0] m);
        case (m)
            MODE_ADD:    return a + b;
            MODE_SUB:    return a - b;
            MODE_AND:    return a & b;
            MODE_OR:     return a | b;
            MODE_XOR:    return a ^ b;
            MODE_PASS_A: return a;
            MODE_PASS_B: return b;
            default:     return '0;
        endcase
    endfunction

    function automatic logic [4*BW-1:0] bundle_ref(input logic [4*BW-1:0] a, input logic [4*BW-1:0] b,
                                                   input logic [3:0] m);
        logic [4*BW-1:0] r;
        for (int l = 0; l < 4; l++) r[l*BW +: BW] = alu_ref(a[l*BW +: BW], b[l*BW +: BW], m);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural SIMD array: SIPO on lane_bits while load, ALU, then PISO
    // onto res_bits starting PISO_LAT cycles after send rises. Outside the
    // result window res_bits carries noise.
    // ------------------------------------------------------------------
    logic [3:0]    m_mode = '0;
    logic [3:0]    m_force_en = '0;
    logic [BW-1:0] m_force [4];
    logic [BW-1:0] m_sa [4];
    logic [BW-1:0] m_sb [4];
    logic [BW-1:0] m_res [4];
    bit            m_in_send = 1'b0;
    int            m_ph = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_in_send = 1'b0;
            res_bits  = '0;
        end else begin
            if (o_load) begin
                for (int l = 0; l < 4; l++) begin
                    m_sa[l] = {m_sa[l][BW-2:0], o_lane_bits[2*l]};
                    m_sb[l] = {m_sb[l][BW-2:0], o_lane_bits[2*l+1]};
                end
            end
            if (o_send && !m_in_send) begin
                m_in_send = 1'b1;
                m_ph = 0;
                for (int l = 0; l < 4; l++)
                    m_res[l] = m_force_en[l] ? m_force[l] : alu_ref(m_sa[l], m_sb[l], m_mode);
            end
            if (m_in_send) begin
                for (int l = 0; l < 4; l++) begin
                    if (m_ph >= PISO_LAT && m_ph < PISO_LAT + BW)
                        res_bits[l] = m_res[l][BW-1-(m_ph-PISO_LAT)];
                    else
                        res_bits[l] = 1'($urandom);
                end
                m_ph++;
                if (m_ph >= BW + PISO_LAT) m_in_send = 1'b0;
            end else begin
                res_bits = 4'($urandom);
            end
        end
    end

    // ------------------------------------------------------------------
    // Drives one operation end to end and reports what was observed.
    // ------------------------------------------------------------------
    task automatic run_op(input logic [4*BW-1:0] a, input logic [4*BW-1:0] b,
                          input logic [3:0] mode, input logic dtype,
                          input int hold, input bit offer_in_hold,
                          output int lat, output logic [4*BW-1:0] res,
                          output int load_cnt, output int lb_err, output int hold_err,
                          output logic [3:0] mode_seen, output logic dtype_seen,
                          output bit timeout);
        int acc;
        int k;
        int guard;
        logic [7:0] exp_lb;
        timeout = 1'b0; lat = 0; res = '0; load_cnt = 0; lb_err = 0; hold_err = 0;
        mode_seen = '0; dtype_seen = 1'b0;
        m_mode = mode;
        @(negedge clk);
        in_a = a; in_b = b; in_mode = mode; in_dtype = dtype; in_valid = 1'b1;
        guard = 0;
        while (!o_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!o_in_ready) begin
            timeout = 1'b1;
            in_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(negedge clk);
        // Anything presented after accept must be ignored.
        in_valid = 1'b0;
        in_mode  = 4'($urandom);
        in_dtype = ~dtype;
        in_a     = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_b     = {$urandom(), $urandom(), $urandom(), $urandom()};
        guard = 0;
        while (!o_out_valid && guard < 4*LAT) begin
            k = cyc - acc - 1;
            if (o_load) load_cnt++;
            if (k < BW) begin
                for (int l = 0; l < 4; l++) begin
                    exp_lb[2*l]   = a[l*BW + BW-1-k];
                    exp_lb[2*l+1] = b[l*BW + BW-1-k];
                end
                if (o_lane_bits !== exp_lb) lb_err++;
            end else if (o_lane_bits !== 8'h00) begin
                lb_err++;
            end
            if (o_in_ready !== 1'b0) lb_err++;
            @(negedge clk);
            guard++;
        end
        if (!o_out_valid) begin
            timeout = 1'b1;
            return;
        end
        lat = cyc - acc;
        res = o_out_res;
        mode_seen = o_mode;
        dtype_seen = o_dtype;
        if (offer_in_hold) in_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            if (o_out_valid !== 1'b1 || o_out_res !== res || o_in_ready !== 1'b0 || o_load !== 1'b0)
                hold_err++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int acc;
        int guard;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({o_load, o_lane_bits, o_mode, o_dtype, o_send, o_out_valid, o_out_res} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got load=%b lb=%h mode=%h send=%b ov=%b res=%h expected all zero",
                     o_load, o_lane_bits, o_mode, o_send, o_out_valid, o_out_res);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (o_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 1", o_in_ready);
        end

        // Abort an operation in LOAD cycle 10.
        m_mode = MODE_PASS_A;
        in_a = {4{32'hFFFF_FFFF}}; in_b = {4{32'h1234_5678}};
        in_mode = MODE_PASS_A; in_dtype = 1'b1; in_valid = 1'b1;
        guard = 0;
        while (!o_in_ready && guard < 50) begin @(negedge clk); guard++; end
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while ((cyc - acc - 1) != 10 && guard < 50) begin @(negedge clk); guard++; end
        tests_run++;
        if (o_load !== 1'b1 || o_lane_bits === 8'h00) begin
            tests_failed++;
            $display("FAIL reset_pre_abort: got load=%b lb=%h expected load=1 lb!=0", o_load, o_lane_bits);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({o_load, o_lane_bits, o_mode, o_dtype, o_send, o_out_valid} !== '0) begin
            tests_failed++;
            $display("FAIL reset_abort: got load=%b lb=%h mode=%h dtype=%b expected all zero",
                     o_load, o_lane_bits, o_mode, o_dtype);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (o_in_ready !== 1'b1 || o_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got in_ready=%b load=%b expected 1 0", o_in_ready, o_load);
        end
    endtask

    task automatic test_lane_bits();
        logic [4*BW-1:0] a, b, res;
        int lat, load_cnt, lb_err, hold_err;
        logic [3:0] ms; logic ds; bit to;
        a = {$urandom(), $urandom(), $urandom(), 32'h8000_0001};
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_op(a, b, MODE_PASS_A, 1'b0, 0, 1'b0, lat, res, load_cnt, lb_err, hold_err, ms, ds, to);
        tests_run++;
        if (to || lb_err != 0) begin
            tests_failed++;
            $display("FAIL lane_bits: got %0d bad cycles (timeout=%0d) expected 0", lb_err, to);
        end
        tests_run++;
        if (load_cnt != BW) begin
            tests_failed++;
            $display("FAIL load_len: got %0d cycles expected %0d", load_cnt, BW);
        end
        tests_run++;
        if (res !== a) begin
            tests_failed++;
            $display("FAIL pass_a_result: got %h expected %h", res, a);
        end
    endtask

    task automatic test_capture();
        logic [4*BW-1:0] a, b, res, exp;
        int lat, load_cnt, lb_err, hold_err;
        logic [3:0] ms; logic ds; bit to;
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        m_force_en = 4'b0001;
        m_force[0] = 32'hDEAD_BEEF;
        run_op(a, b, MODE_PASS_A, 1'b0, 0, 1'b0, lat, res, load_cnt, lb_err, hold_err, ms, ds, to);
        m_force_en = 4'b0000;
        exp = a;
        exp[BW-1:0] = 32'hDEAD_BEEF;
        tests_run++;
        if (to || res !== exp) begin
            tests_failed++;
            $display("FAIL capture_deadbeef: got %h expected %h", res, exp);
        end
        tests_run++;
        if (lat != LAT) begin
            tests_failed++;
            $display("FAIL latency: got %0d expected %0d", lat, LAT);
        end
    endtask

    task automatic test_add();
        logic [4*BW-1:0] res;
        int lat, load_cnt, lb_err, hold_err;
        logic [3:0] ms; logic ds; bit to;
        run_op({4{32'h0000_0005}}, {4{32'h0000_0003}}, MODE_ADD, 1'b1, 0, 1'b0,
               lat, res, load_cnt, lb_err, hold_err, ms, ds, to);
        tests_run++;
        if (to || res !== {4{32'h0000_0008}}) begin
            tests_failed++;
            $display("FAIL add_all_lanes: got %h expected %h", res, {4{32'h0000_0008}});
        end
        tests_run++;
        if (ms !== 4'(MODE_ADD) || ds !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_mode_latch: got mode=%h dtype=%b expected %h 1", ms, ds, 4'(MODE_ADD));
        end
    endtask

    task automatic test_backpressure();
        logic [4*BW-1:0] a, b, res;
        int lat, load_cnt, lb_err, hold_err;
        logic [3:0] ms; logic ds; bit to;
        a = {$urandom(), $urandom(), $urandom(), $urandom()};
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_op(a, b, MODE_XOR, 1'b0, 20, 1'b1, lat, res, load_cnt, lb_err, hold_err, ms, ds, to);
        tests_run++;
        if (to || hold_err != 0) begin
            tests_failed++;
            $display("FAIL backpressure_hold: got %0d unstable cycles (timeout=%0d) expected 0", hold_err, to);
        end
        tests_run++;
        if (res !== bundle_ref(a, b, MODE_XOR)) begin
            tests_failed++;
            $display("FAIL backpressure_result: got %h expected %h", res, bundle_ref(a, b, MODE_XOR));
        end
        // One cycle after the handshake: IDLE with the offered bundle pending.
        tests_run++;
        if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || o_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_handshake_idle: got in_ready=%b out_valid=%b load=%b expected 1 0 0",
                     o_in_ready, o_out_valid, o_load);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (o_load !== 1'b1) begin
            tests_failed++;
            $display("FAIL second_accept: got load=%b expected 1", o_load);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] modes [7];
        logic [4*BW-1:0] a, b, res, exp;
        logic [3:0] m, ms;
        logic d, ds;
        int lat, load_cnt, lb_err, hold_err, hold;
        bit to;
        modes = '{MODE_ADD, MODE_SUB, MODE_AND, MODE_OR, MODE_XOR, MODE_PASS_A, MODE_PASS_B};
        for (int n = 0; n < 6; n++) begin
            a = {$urandom(), $urandom(), $urandom(), $urandom()};
            b = {$urandom(), $urandom(), $urandom(), $urandom()};
            m = modes[$urandom_range(0, 6)];
            d = 1'($urandom);
            hold = $urandom_range(0, 3);
            run_op(a, b, m, d, hold, 1'b0, lat, res, load_cnt, lb_err, hold_err, ms, ds, to);
            exp = bundle_ref(a, b, m);
            tests_run++;
            if (to || res !== exp) begin
                tests_failed++;
                $display("FAIL random_result[%0d]: mode=%h got %h expected %h", n, m, res, exp);
            end
            tests_run++;
            if (lat != LAT || load_cnt != BW || lb_err != 0 || hold_err != 0) begin
                tests_failed++;
                $display("FAIL random_timing[%0d]: got lat=%0d load=%0d lb_err=%0d hold_err=%0d expected %0d %0d 0 0",
                         n, lat, load_cnt, lb_err, hold_err, LAT, BW);
            end
            tests_run++;
            if (ms !== m || ds !== d) begin
                tests_failed++;
                $display("FAIL random_mode[%0d]: got mode=%h dtype=%b expected %h %b", n, ms, ds, m, d);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4*BW-1:0] a, b, res;
        int lat, load_cnt, lb_err, hold_err;
        logic [3:0] ms; logic ds; bit to;
`ifdef SIMD_SEQ_OPCNT_EN
        logic [15:0] cnt0;
        cnt0 = o_op_count;
`endif
        for (int n = 0; n < 3; n++) begin
            a = {$urandom(), $urandom(), $urandom(), $urandom()};
            b = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_op(a, b, MODE_SUB, 1'b0, 0, 1'b0, lat, res, load_cnt, lb_err, hold_err, ms, ds, to);
            tests_run++;
            if (to || res !== bundle_ref(a, b, MODE_SUB)) begin
                tests_failed++;
                $display("FAIL b2b_result[%0d]: got %h expected %h", n, res, bundle_ref(a, b, MODE_SUB));
            end
        end
`ifdef SIMD_SEQ_OPCNT_EN
        tests_run++;
        if (o_op_count !== cnt0 + 16'd3) begin
            tests_failed++;
            $display("FAIL op_count: got %0d expected %0d", o_op_count, cnt0 + 16'd3);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lane_bits();
        test_capture();
        test_add();
        test_backpressure();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
